// File: rtl/bids22_round_seq.sv
// Round sequencer for the bids22 auction unit: unlock, load config, lock,
// strobe C_start for the programmed length, then collect the round result.
module bids22_round_seq #(
  parameter int RO_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        go_i,
  input  logic        abort_i,
  input  logic [31:0] cfg_key_i,
  input  logic [31:0] cfg_x_bal_i,
  input  logic [31:0] cfg_y_bal_i,
  input  logic [31:0] cfg_z_bal_i,
  input  logic [2:0]  cfg_mask_i,
  input  logic [31:0] cfg_timer_i,
  input  logic [31:0] cfg_cost_i,
  input  logic [15:0] cfg_round_len_i,
  input  logic        ready_i,
  input  logic        roundOver_i,
  input  logic [1:0]  err_i,
  input  logic        X_win_i,
  input  logic        Y_win_i,
  input  logic        Z_win_i,
  input  logic [31:0] maxBid_i,
  output logic [3:0]  C_op_o,
  output logic [31:0] C_data_o,
  output logic        C_start_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [2:0]  status_o,
  output logic [1:0]  err_code_o,
  output logic [1:0]  win_id_o,
  output logic [31:0] win_amt_o
);

  localparam int TW = $clog2(RO_TIMEOUT + 1);

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_UNLOCK = 4'd1;
  localparam logic [3:0] OP_LOCK   = 4'd2;
  localparam logic [3:0] OP_LOADX  = 4'd3;
  localparam logic [3:0] OP_LOADY  = 4'd4;
  localparam logic [3:0] OP_LOADZ  = 4'd5;
  localparam logic [3:0] OP_MASK   = 4'd6;
  localparam logic [3:0] OP_TIMER  = 4'd7;
  localparam logic [3:0] OP_CHARGE = 4'd8;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_UNITERR = 3'd1;
  localparam logic [2:0] ST_TIMEOUT = 3'd2;
  localparam logic [2:0] ST_NOWIN   = 3'd3;
  localparam logic [2:0] ST_ABORT   = 3'd4;

  typedef enum logic [2:0] {IDLE, WAIT_RDY, ISSUE, CHECK, ROUND, CLOSE, DONE} state_e;

  typedef struct packed {
    logic [31:0] key;
    logic [31:0] x_bal;
    logic [31:0] y_bal;
    logic [31:0] z_bal;
    logic [2:0]  mask;
    logic [31:0] timer;
    logic [31:0] cost;
    logic [15:0] round_len;
  } cfg_t;

  state_e        state_q, state_d;
  cfg_t          cfg_q, cfg_d;
  logic [2:0]    op_idx_q, op_idx_d;
  logic          locked_q, locked_d;
  logic [31:0]   key_q, key_d;
  logic [15:0]   len_q, len_d;
  logic [TW-1:0] to_q, to_d;

  logic [3:0]  C_op_q, C_op_d;
  logic [31:0] C_data_q, C_data_d;
  logic        C_start_q, C_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  status_q, status_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [1:0]  win_id_q, win_id_d;
  logic [31:0] win_amt_q, win_amt_d;

  logic [3:0]  op_code;
  logic [31:0] op_data;

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    op_idx_d   = op_idx_q;
    locked_d   = locked_q;
    key_d      = key_q;
    len_d      = len_q;
    to_d       = to_q;
    status_d   = status_q;
    err_code_d = err_code_q;
    win_id_d   = win_id_q;
    win_amt_d  = win_amt_q;

    case (state_q)
      IDLE: begin
        if (go_i) begin
          cfg_d      = '{key: cfg_key_i, x_bal: cfg_x_bal_i, y_bal: cfg_y_bal_i,
                         z_bal: cfg_z_bal_i, mask: cfg_mask_i, timer: cfg_timer_i,
                         cost: cfg_cost_i, round_len: cfg_round_len_i};
          status_d   = ST_OK;
          err_code_d = 2'd0;
          win_id_d   = 2'd0;
          win_amt_d  = 32'd0;
          // Unlock (index 0) is only needed if a previous round left the unit locked.
          op_idx_d   = locked_q ? 3'd0 : 3'd1;
          state_d    = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (abort_i) begin
          status_d = ST_ABORT;
          state_d  = DONE;
        end else if (ready_i) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (abort_i) begin
          status_d = ST_ABORT;
          state_d  = DONE;
        end else begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (err_i != 2'd0) begin
          err_code_d = err_i;
          status_d   = ST_UNITERR;
          state_d    = DONE;
        end else begin
          // The op just went through cleanly, so the lock state is confirmed
          // even if an abort arrives in this same cycle.
          if (op_idx_q == 3'd0) locked_d = 1'b0;
          if (op_idx_q == 3'd7) begin
            locked_d = 1'b1;
            key_d    = cfg_q.key;
          end
          if (abort_i) begin
            status_d = ST_ABORT;
            state_d  = DONE;
          end else if (op_idx_q == 3'd7) begin
            len_d   = (cfg_q.round_len == 16'd0) ? 16'd1 : cfg_q.round_len;
            state_d = ROUND;
          end else begin
            op_idx_d = op_idx_q + 3'd1;
            state_d  = ISSUE;
          end
        end
      end
      ROUND: begin
        len_d = len_q - 16'd1;
        if (len_q <= 16'd1 || abort_i) begin
          to_d    = '0;
          state_d = CLOSE;
        end
      end
      CLOSE: begin
        if (roundOver_i) begin
          state_d = DONE;
          unique case ({X_win_i, Y_win_i, Z_win_i})
            3'b100:  begin win_id_d = 2'd1; win_amt_d = maxBid_i; status_d = ST_OK; end
            3'b010:  begin win_id_d = 2'd2; win_amt_d = maxBid_i; status_d = ST_OK; end
            3'b001:  begin win_id_d = 2'd3; win_amt_d = maxBid_i; status_d = ST_OK; end
            default: begin win_id_d = 2'd0; win_amt_d = 32'd0;    status_d = ST_NOWIN; end
          endcase
        end else if (to_q == TW'(RO_TIMEOUT - 1)) begin
          win_id_d  = 2'd0;
          win_amt_d = 32'd0;
          status_d  = ST_TIMEOUT;
          state_d   = DONE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_code = OP_NOP;
    op_data = 32'd0;
    case (op_idx_d)
      3'd0: begin op_code = OP_UNLOCK; op_data = key_q;                 end
      3'd1: begin op_code = OP_LOADX;  op_data = cfg_q.x_bal;           end
      3'd2: begin op_code = OP_LOADY;  op_data = cfg_q.y_bal;           end
      3'd3: begin op_code = OP_LOADZ;  op_data = cfg_q.z_bal;           end
      3'd4: begin op_code = OP_MASK;   op_data = {29'd0, cfg_q.mask};   end
      3'd5: begin op_code = OP_TIMER;  op_data = cfg_q.timer;           end
      3'd6: begin op_code = OP_CHARGE; op_data = cfg_q.cost;            end
      default: begin op_code = OP_LOCK; op_data = cfg_q.key;            end
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    C_op_d    = (state_d == ISSUE) ? op_code : OP_NOP;
    C_data_d  = (state_d == ISSUE) ? op_data : 32'd0;
    C_start_d = (state_d == ROUND);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      op_idx_q   <= 3'd0;
      locked_q   <= 1'b0;
      key_q      <= 32'd0;
      len_q      <= 16'd0;
      to_q       <= '0;
      C_op_q     <= OP_NOP;
      C_data_q   <= 32'd0;
      C_start_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= 3'd0;
      err_code_q <= 2'd0;
      win_id_q   <= 2'd0;
      win_amt_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      op_idx_q   <= op_idx_d;
      locked_q   <= locked_d;
      key_q      <= key_d;
      len_q      <= len_d;
      to_q       <= to_d;
      C_op_q     <= C_op_d;
      C_data_q   <= C_data_d;
      C_start_q  <= C_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      status_q   <= status_d;
      err_code_q <= err_code_d;
      win_id_q   <= win_id_d;
      win_amt_q  <= win_amt_d;
    end
  end

  assign C_op_o     = C_op_q;
  assign C_data_o   = C_data_q;
  assign C_start_o  = C_start_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign status_o   = status_q;
  assign err_code_o = err_code_q;
  assign win_id_o   = win_id_q;
  assign win_amt_o  = win_amt_q;

endmodule
